// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd F(4x4,3x3) transform blocks.
package winograd_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned TILE_OUT           = 4;
    localparam int unsigned KERNEL             = 3;
    localparam int unsigned TILE_IN            = TILE_OUT + KERNEL - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC_T = 2'd1,
        S_CALC_V = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] element_t;

endpackage

// File: rtl/winograd_bt_1d.sv
// Combinational 6-point B^T vector transform using shifts and adds only.
module winograd_bt_1d
    import winograd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] d [TILE_IN],
    output logic [DATA_WIDTH-1:0] v [TILE_IN]
);

    logic [DATA_WIDTH-1:0] d0x4;
    logic [DATA_WIDTH-1:0] d1x2;
    logic [DATA_WIDTH-1:0] d1x4;
    logic [DATA_WIDTH-1:0] d2x4;
    logic [DATA_WIDTH-1:0] d2x5;
    logic [DATA_WIDTH-1:0] d3x2;
    logic [DATA_WIDTH-1:0] d3x5;
    logic [DATA_WIDTH-1:0] sum_a;
    logic [DATA_WIDTH-1:0] sum_b;
    logic [DATA_WIDTH-1:0] sum_c;
    logic [DATA_WIDTH-1:0] sum_e;

    // Rows 1/2 and 3/4 are sum/difference pairs sharing partial terms.
    always_comb begin
        d0x4  = d[0] << 2;
        d1x2  = d[1] << 1;
        d1x4  = d[1] << 2;
        d2x4  = d[2] << 2;
        d2x5  = (d[2] << 2) + d[2];
        d3x2  = d[3] << 1;
        d3x5  = (d[3] << 2) + d[3];
        sum_a = d[4] - d2x4;
        sum_b = d1x4 - d[3];
        sum_c = d[4] - d[2];
        sum_e = d1x2 - d3x2;
        v[0]  = d0x4 - d2x5 + d[4];
        v[1]  = sum_a - sum_b;
        v[2]  = sum_a + sum_b;
        v[3]  = sum_c - sum_e;
        v[4]  = sum_c + sum_e;
        v[5]  = d1x4 - d3x5 + d[5];
    end

endmodule

// File: rtl/forward_transform_unit.sv
// Winograd F(4x4,3x3) input-tile transform V = B^T * D * B; six time-shared
// 1-D lanes process columns of D in S_CALC_T and rows of T in S_CALC_V.
module forward_transform_unit
    import winograd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tile_in  [0:5][0:5],
    output logic [DATA_WIDTH-1:0] tile_out [0:5][0:5],
    output logic                  busy,
    output logic                  transform_done
);

    state_e state_q;
    state_e state_d;
    logic   capture_c;
    logic   calc_t_c;
    logic   calc_v_c;
    logic   done_d;

    logic [DATA_WIDTH-1:0] d_r      [TILE_IN][TILE_IN];
    logic [DATA_WIDTH-1:0] t_r      [TILE_IN][TILE_IN];
    logic [DATA_WIDTH-1:0] lane_in  [TILE_IN][TILE_IN];
    logic [DATA_WIDTH-1:0] lane_out [TILE_IN][TILE_IN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = S_IDLE;
        capture_c = 1'b0;
        calc_t_c  = 1'b0;
        calc_v_c  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture_c = 1'b1;
                    state_d   = S_CALC_T;
                end
            end
            S_CALC_T: begin
                calc_t_c = 1'b1;
                state_d  = S_CALC_V;
            end
            S_CALC_V: begin
                calc_v_c = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // Lane l sees column l of D_r while building T, row l of T while building V.
    for (genvar l = 0; l < TILE_IN; l++) begin : g_lane
        for (genvar e = 0; e < TILE_IN; e++) begin : g_elem
            assign lane_in[l][e] = (state_q == S_CALC_V) ? t_r[l][e] : d_r[e][l];
        end
        winograd_bt_1d #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bt (
            .d(lane_in[l]),
            .v(lane_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    d_r[i][j]      <= '0;
                    t_r[i][j]      <= '0;
                    tile_out[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    if (capture_c) begin
                        d_r[i][j] <= tile_in[i][j];
                    end
                    if (calc_t_c) begin
                        t_r[i][j] <= lane_out[j][i];
                    end
                    if (calc_v_c) begin
                        tile_out[i][j] <= lane_out[i][j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            transform_done <= 1'b0;
        end else begin
            transform_done <= done_d;
        end
    end

endmodule

// File: tb/tb_forward_transform_unit.sv
// Bench for forward_transform_unit: directed and random tiles against a matrix model.
module tb_forward_transform_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] tile_in  [6][6];
    logic [15:0] tile_out [6][6];
    logic        busy;
    logic        transform_done;

    int total = 0;
    int bad   = 0;

    int bt [6][6] = '{
        '{ 4,  0, -5,  0, 1, 0},
        '{ 0, -4, -4,  1, 1, 0},
        '{ 0,  4, -4, -1, 1, 0},
        '{ 0, -2, -1,  2, 1, 0},
        '{ 0,  2, -1, -2, 1, 0},
        '{ 0,  4,  0, -5, 0, 1}
    };

    always #5 clk = ~clk;

    forward_transform_unit #(
        .DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .tile_in(tile_in),
        .tile_out(tile_out),
        .busy(busy),
        .transform_done(transform_done)
    );

    // V = B^T * D * B with 16-bit wrap.
    function automatic void model(input logic [15:0] d [6][6], output logic [15:0] v [6][6]);
        int t [6][6];
        int acc;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                acc = 0;
                for (int k = 0; k < 6; k++) acc += bt[i][k] * int'(signed'(d[k][j]));
                t[i][j] = int'(signed'(16'(acc)));
            end
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                acc = 0;
                for (int k = 0; k < 6; k++) acc += t[i][k] * bt[j][k];
                v[i][j] = 16'(acc);
            end
        end
    endfunction

    function automatic int tile_diff(input logic [15:0] a [6][6], input logic [15:0] b [6][6]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if (a[i][j] !== b[i][j]) return i * 6 + j;
        return -1;
    endfunction

    function automatic void rand_tile(output logic [15:0] d [6][6]);
        foreach (d[i, j]) d[i][j] = 16'($urandom);
    endfunction

    // Start one tile and return cycles from the accepting edge to done (-1 on timeout).
    task automatic do_tile(input logic [15:0] d [6][6], output int lat);
        tile_in = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (transform_done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] z [6][6];
        int idx;
        foreach (z[i, j]) z[i][j] = 16'h0;
        rst_n   = 1'b0;
        start   = 1'b0;
        tile_in = z;
        #12;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (transform_done !== 1'b0) begin
            bad++; $display("FAIL reset_done: got %b want 0", transform_done);
        end
        total++;
        idx = tile_diff(tile_out, z);
        if (idx != -1) begin
            bad++; $display("FAIL reset_tile: V[%0d][%0d] got %h want 0000", idx / 6, idx % 6, tile_out[idx / 6][idx % 6]);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [15:0] d [6][6];
        logic [15:0] e [6][6];
        int key_i [5] = '{1, 0, 0, 0, 5};
        int key_j [5] = '{1, 0, 1, 0, 5};
        logic [15:0] key_v [5] = '{16'h0024, 16'h0010, 16'h0014, 16'h0000, 16'hFFFF};
        int lat;
        int idx;
        for (int p = 0; p < 5; p++) begin
            foreach (d[i, j]) d[i][j] = (p == 0) ? 16'd1 : 16'd0;
            case (p)
                1: d[0][0] = 16'd1;
                2: d[2][2] = 16'd1;
                3: d[0][0] = 16'h1000;
                4: d[5][5] = 16'hFFFF;
                default: ;
            endcase
            model(d, e);
            do_tile(d, lat);
            total++;
            if (lat !== 3) begin
                bad++; $display("FAIL directed%0d_latency: got %0d want 3", p, lat);
            end
            total++;
            if (tile_out[key_i[p]][key_j[p]] !== key_v[p]) begin
                bad++; $display("FAIL directed%0d_key: V[%0d][%0d] got %h want %h", p, key_i[p], key_j[p],
                                tile_out[key_i[p]][key_j[p]], key_v[p]);
            end
            total++;
            idx = tile_diff(tile_out, e);
            if (idx != -1) begin
                bad++; $display("FAIL directed%0d_tile: V[%0d][%0d] got %h want %h", p, idx / 6, idx % 6,
                                tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
            end
        end
        total++;
        if (tile_out[3][3] !== 16'h0000 || tile_out[1][1] !== 16'h0000) begin
            bad++; $display("FAIL directed_zero: V[3][3]=%h V[1][1]=%h want 0000", tile_out[3][3], tile_out[1][1]);
        end
    endtask

    task automatic test_random;
        logic [15:0] d [6][6];
        logic [15:0] e [6][6];
        int lat;
        int idx;
        for (int n = 0; n < 8; n++) begin
            rand_tile(d);
            model(d, e);
            do_tile(d, lat);
            total++;
            if (lat !== 3) begin
                bad++; $display("FAIL random%0d_latency: got %0d want 3", n, lat);
            end
            total++;
            idx = tile_diff(tile_out, e);
            if (idx != -1) begin
                bad++; $display("FAIL random%0d_tile: V[%0d][%0d] got %h want %h", n, idx / 6, idx % 6,
                                tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
            end
        end
    endtask

    task automatic test_input_change;
        logic [15:0] a [6][6];
        logic [15:0] b [6][6];
        logic [15:0] e [6][6];
        int lat;
        int idx;
        rand_tile(a);
        rand_tile(b);
        model(a, e);
        tile_in = a;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        tile_in = b;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (transform_done) begin
                lat = c;
                break;
            end
        end
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL input_change_latency: got %0d want 3", lat);
        end
        total++;
        idx = tile_diff(tile_out, e);
        if (idx != -1) begin
            bad++; $display("FAIL input_change_tile: V[%0d][%0d] got %h want %h", idx / 6, idx % 6,
                            tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
        end
    endtask

    task automatic test_start_while_busy;
        logic [15:0] a [6][6];
        logic [15:0] b [6][6];
        logic [15:0] e [6][6];
        int ndone;
        int lat;
        int idx;
        rand_tile(a);
        rand_tile(b);
        model(a, e);
        tile_in = a;
        start   = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_calc_t: got %b want 1", busy);
        end
        tile_in = b;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (transform_done) begin
                ndone++;
                if (lat < 0) lat = c + 1;
            end
        end
        total++;
        if (ndone !== 1) begin
            bad++; $display("FAIL busy_start_done_count: got %0d want 1", ndone);
        end
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL busy_start_latency: got %0d want 3", lat);
        end
        total++;
        idx = tile_diff(tile_out, e);
        if (idx != -1) begin
            bad++; $display("FAIL busy_start_tile: V[%0d][%0d] got %h want %h", idx / 6, idx % 6,
                            tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] tiles [5][6][6];
        logic [15:0] e [6][6];
        int seen;
        int last;
        int gap;
        int idx;
        for (int n = 0; n < 5; n++) rand_tile(tiles[n]);
        tile_in = tiles[0];
        start   = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        last = 0;
        for (int c = 1; c <= 30 && seen < 5; c++) begin
            @(posedge clk); #1;
            if (transform_done) begin
                model(tiles[seen], e);
                gap  = c - last;
                last = c;
                total++;
                if (gap !== ((seen == 0) ? 3 : 4)) begin
                    bad++; $display("FAIL b2b%0d_gap: got %0d want %0d", seen, gap, (seen == 0) ? 3 : 4);
                end
                total++;
                idx = tile_diff(tile_out, e);
                if (idx != -1) begin
                    bad++; $display("FAIL b2b%0d_tile: V[%0d][%0d] got %h want %h", seen, idx / 6, idx % 6,
                                    tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
                end
                seen++;
                if (seen < 5) tile_in = tiles[seen];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (seen !== 5) begin
            bad++; $display("FAIL b2b_count: got %0d dones want 5", seen);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] a [6][6];
        logic [15:0] e [6][6];
        logic [15:0] z [6][6];
        int ndone;
        int lat;
        int idx;
        foreach (z[i, j]) z[i][j] = 16'h0;
        rand_tile(a);
        tile_in = a;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        idx = tile_diff(tile_out, z);
        if (idx != -1) begin
            bad++; $display("FAIL rst_mid_tile: V[%0d][%0d] got %h want 0000", idx / 6, idx % 6, tile_out[idx / 6][idx % 6]);
        end
        total++;
        if (transform_done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_flags: done=%b busy=%b want 0 0", transform_done, busy);
        end
        #2 rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (transform_done) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++; $display("FAIL rst_mid_no_done: got %0d dones want 0", ndone);
        end
        rand_tile(a);
        model(a, e);
        do_tile(a, lat);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL rst_mid_after_latency: got %0d want 3", lat);
        end
        total++;
        idx = tile_diff(tile_out, e);
        if (idx != -1) begin
            bad++; $display("FAIL rst_mid_after_tile: V[%0d][%0d] got %h want %h", idx / 6, idx % 6,
                            tile_out[idx / 6][idx % 6], e[idx / 6][idx % 6]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_input_change();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
